axi_mst: RTL

AXI_MST -- requirements
Module: axi_mst

---
 rtl/axi_mst.sv | 303 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/axi_mst.sv
// rtl/axi_mst.sv - single-outstanding AXI4 master, one beat per command
//
// Turns one command at a time into a single-beat AXI4 read (AR/R) or write
// (AW/W/B) and hands the result back on a response handshake.
//
// Parameters
//   TAGW            width of arid/awid/rid/bid
//   TIMEOUT_CYCLES  response-wait limit in cycles (1..65535), used only when
//                   RV_AXI_MST_TIMEOUT_EN is defined
//
// Optional feature macro: RV_AXI_MST_TIMEOUT_EN
//   defined   - R/B waits are bounded; expiry gives rsp_timeout=1, rsp_resp=SLVERR
//   undefined - no wait counter, rsp_timeout tied 0, waits are unbounded
//
// Ports
//   aclk, rst_l                     clock, async active-low reset
//   cmd_*                           command in (valid/ready, write, addr, size, wdata, wstrb)
//   rsp_*                           response out (valid/ready, rdata, resp, id_err, timeout)
//   ar*, r*, aw*, w*, b*            AXI4 master channels
module axi_mst #(
    parameter int unsigned TAGW           = 1,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic            aclk,
    input  logic            rst_l,

    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_write,
    input  logic [31:0]     cmd_addr,
    input  logic [2:0]      cmd_size,
    input  logic [63:0]     cmd_wdata,
    input  logic [7:0]      cmd_wstrb,

    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [63:0]     rsp_rdata,
    output logic [1:0]      rsp_resp,
    output logic            rsp_id_err,
    output logic            rsp_timeout,

    output logic            arvalid,
    input  logic            arready,
    output logic [31:0]     araddr,
    output logic [TAGW-1:0] arid,
    output logic [7:0]      arlen,
    output logic [1:0]      arburst,
    output logic [2:0]      arsize,

    input  logic            rvalid,
    output logic            rready,
    input  logic [63:0]     rdata,
    input  logic [1:0]      rresp,
    input  logic [TAGW-1:0] rid,
    input  logic            rlast,

    output logic            awvalid,
    input  logic            awready,
    output logic [31:0]     awaddr,
    output logic [TAGW-1:0] awid,
    output logic [7:0]      awlen,
    output logic [1:0]      awburst,
    output logic [2:0]      awsize,

    output logic            wvalid,
    input  logic            wready,
    output logic [63:0]     wdata,
    output logic [7:0]      wstrb,
    output logic            wlast,

    input  logic            bvalid,
    output logic            bready,
    input  logic [1:0]      bresp,
    input  logic [TAGW-1:0] bid
);

    typedef enum logic [2:0] {
        IDLE,
        RADDR,
        RDATA,
        WREQ,
        WRESP,
        RSP
    } state_e;

    state_e            state_q, state_d;
    logic [31:0]       addr_q, addr_d;
    logic [2:0]        size_q, size_d;
    logic [63:0]       wdata_q, wdata_d;
    logic [7:0]        wstrb_q, wstrb_d;
    logic [TAGW-1:0]   id_q, id_d;          // ID issued for the current transaction
    logic [TAGW-1:0]   id_cnt_q, id_cnt_d;  // ID for the next accepted command
    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;
    logic [63:0]       rsp_rdata_q, rsp_rdata_d;
    logic [1:0]        rsp_resp_q, rsp_resp_d;
    logic              rsp_id_err_q, rsp_id_err_d;

    logic              aw_fire;
    logic              w_fire;

    // Bursts are always one beat, so rlast carries no extra information.
    logic              unused_rlast;
    assign unused_rlast = rlast;

`ifdef RV_AXI_MST_TIMEOUT_EN
    localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0]       timer_q, timer_d;
    logic              rsp_timeout_q, rsp_timeout_d;
    logic              timeout_hit;

    // Counter sits at zero outside the wait states, so it is cleared on
    // entry and counts cycles spent waiting for R or B.
    always_comb begin
        timer_d = 16'd0;
        if (state_q == RDATA || state_q == WRESP) begin
            timer_d = timer_q + 16'd1;
        end
    end

    // Expires on the last waiting cycle so RSP is reached exactly
    // TIMEOUT_CYCLES cycles after entering the wait state.
    assign timeout_hit = (timer_q == TIMER_LAST);
    assign rsp_timeout = rsp_timeout_q;
`else
    assign rsp_timeout = 1'b0;
`endif

    assign cmd_ready  = (state_q == IDLE);
    assign rsp_valid  = (state_q == RSP);
    assign rsp_rdata  = rsp_rdata_q;
    assign rsp_resp   = rsp_resp_q;
    assign rsp_id_err = rsp_id_err_q;

    assign arvalid = (state_q == RADDR);
    assign araddr  = addr_q;
    assign arid    = id_q;
    assign arlen   = 8'd0;
    assign arburst = 2'b01;
    assign arsize  = size_q;
    assign rready  = (state_q == RDATA);

    // AW and W complete independently; each valid drops after its own handshake.
    assign awvalid = (state_q == WREQ) && !aw_done_q;
    assign awaddr  = addr_q;
    assign awid    = id_q;
    assign awlen   = 8'd0;
    assign awburst = 2'b01;
    assign awsize  = size_q;

    assign wvalid  = (state_q == WREQ) && !w_done_q;
    assign wdata   = wdata_q;
    assign wstrb   = wstrb_q;
    assign wlast   = 1'b1;
    assign bready  = (state_q == WRESP);

    assign aw_fire = awvalid && awready;
    assign w_fire  = wvalid && wready;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        size_d       = size_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        id_d         = id_q;
        id_cnt_d     = id_cnt_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_resp_d   = rsp_resp_q;
        rsp_id_err_d = rsp_id_err_q;
`ifdef RV_AXI_MST_TIMEOUT_EN
        rsp_timeout_d = rsp_timeout_q;
`endif

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d    = cmd_addr;
                    size_d    = cmd_size;
                    wdata_d   = cmd_wdata;
                    wstrb_d   = cmd_wstrb;
                    id_d      = id_cnt_q;
                    id_cnt_d  = id_cnt_q + TAGW'(1);
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = cmd_write ? WREQ : RADDR;
                end
            end

            RADDR: begin
                if (arready) begin
                    state_d = RDATA;
                end
            end

            RDATA: begin
                if (rvalid) begin
                    rsp_rdata_d  = rdata;
                    rsp_resp_d   = rresp;
                    rsp_id_err_d = (rid != id_q);
`ifdef RV_AXI_MST_TIMEOUT_EN
                    rsp_timeout_d = 1'b0;
`endif
                    state_d      = RSP;
                end
`ifdef RV_AXI_MST_TIMEOUT_EN
                else if (timeout_hit) begin
                    rsp_rdata_d   = 64'd0;
                    rsp_resp_d    = 2'b10;
                    rsp_id_err_d  = 1'b0;
                    rsp_timeout_d = 1'b1;
                    state_d       = RSP;
                end
`endif
            end

            WREQ: begin
                aw_done_d = aw_done_q || aw_fire;
                w_done_d  = w_done_q || w_fire;
                if ((aw_done_q || aw_fire) && (w_done_q || w_fire)) begin
                    state_d = WRESP;
                end
            end

            WRESP: begin
                if (bvalid) begin
                    rsp_rdata_d  = 64'd0;
                    rsp_resp_d   = bresp;
                    rsp_id_err_d = (bid != id_q);
`ifdef RV_AXI_MST_TIMEOUT_EN
                    rsp_timeout_d = 1'b0;
`endif
                    state_d      = RSP;
                end
`ifdef RV_AXI_MST_TIMEOUT_EN
                else if (timeout_hit) begin
                    rsp_rdata_d   = 64'd0;
                    rsp_resp_d    = 2'b10;
                    rsp_id_err_d  = 1'b0;
                    rsp_timeout_d = 1'b1;
                    state_d       = RSP;
                end
`endif
            end

            RSP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge rst_l) begin
        if (!rst_l) begin
            state_q      <= IDLE;
            addr_q       <= 32'd0;
            size_q       <= 3'd0;
            wdata_q      <= 64'd0;
            wstrb_q      <= 8'd0;
            id_q         <= '0;
            id_cnt_q     <= '0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            rsp_rdata_q  <= 64'd0;
            rsp_resp_q   <= 2'd0;
            rsp_id_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            size_q       <= size_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            id_q         <= id_d;
            id_cnt_q     <= id_cnt_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_resp_q   <= rsp_resp_d;
            rsp_id_err_q <= rsp_id_err_d;
        end
    end

`ifdef RV_AXI_MST_TIMEOUT_EN
    always_ff @(posedge aclk or negedge rst_l) begin
        if (!rst_l) begin
            timer_q       <= 16'd0;
            rsp_timeout_q <= 1'b0;
        end else begin
            timer_q       <= timer_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end
`endif

endmodule
